// File: rtl/arb_requester_if.sv
`default_nettype none
// ============================================================================
// Module  : arb_requester_if
// Brief   : Upstream valid/ready, arbiter req/gnt and drain bundle for arb_requester.
// Revision: 1.0  initial release
// ============================================================================
interface arb_requester_if #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
);
  localparam int c_wcw = $clog2(TIMEOUT + 1);

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             req;
  logic             gnt;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             starve;
  logic [c_wcw-1:0] wait_cnt;

  // master is the requester agent itself
  modport master (
    input  in_valid, in_data, gnt,
    output in_ready, req, out_valid, out_data, starve, wait_cnt
  );

  modport slave (
    output in_valid, in_data, gnt,
    input  in_ready, req, out_valid, out_data, starve, wait_cnt
  );
endinterface
`default_nettype wire

// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module  : arb_requester
// Brief   : FIFO-buffered arbiter client with burst cap, fairness gap and starvation flag.
// Revision: 1.0  initial release
// ============================================================================
module arb_requester #(
  parameter int DW        = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  arb_requester_if.master bus
);
  localparam int c_aw  = $clog2(DEPTH);
  localparam int c_wcw = $clog2(TIMEOUT + 1);
  localparam int c_bcw = $clog2(MAX_BURST + 1);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_req     = 2'd1;
  localparam logic [1:0] c_release = 2'd2;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [c_bcw-1:0] r_burst_cnt;
  logic [c_wcw-1:0] r_wait_cnt;
  logic [c_wcw-1:0] w_wait_nxt;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic             r_starve;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last_pop;
  logic [c_aw:0]    w_count;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

  assign w_push = bus.in_valid & ~w_full;
  assign w_pop  = (r_state == c_req) & bus.gnt;

  // Tenure ends on the burst cap or when this pop drains the FIFO
  assign w_last_pop = w_pop &
                      ((r_burst_cnt == c_bcw'(MAX_BURST - 1)) ||
                       ((w_count == (c_aw + 1)'(1)) && !w_push));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:    if (!w_empty) w_state_nxt = c_req;
      c_req:     if (w_last_pop) w_state_nxt = c_release;
      c_release: w_state_nxt = w_empty ? c_idle : c_req;
      default:   w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_wait_nxt = '0;
    if ((r_state == c_req) && !bus.gnt) begin
      w_wait_nxt = (r_wait_cnt == c_wcw'(TIMEOUT)) ? r_wait_cnt : r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_burst_cnt <= '0;
      r_wait_cnt  <= '0;
      r_starve    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_starve    <= (w_wait_nxt == c_wcw'(TIMEOUT));
      r_out_valid <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_out_data  <= r_mem[r_rd_ptr[c_aw-1:0]];
        r_burst_cnt <= w_last_pop ? '0 : r_burst_cnt + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= bus.in_data;
  end

  assign bus.in_ready  = ~w_full;
  assign bus.req       = (r_state == c_req);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.starve    = r_starve;
  assign bus.wait_cnt  = r_wait_cnt;
endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`default_nettype none
// ============================================================================
// Module  : tb_arb_requester
// Brief   : Directed self-checking bench for arb_requester.
// Revision: 1.0  initial release
// ============================================================================
module tb_arb_requester;
  localparam int DW        = 8;
  localparam int DEPTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  arb_requester_if #(.DW(DW), .TIMEOUT(TIMEOUT)) bus ();

  arb_requester #(
    .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.gnt = 1'b1;
    repeat (3) tick();
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.req); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    n_vec++; if (bus.starve !== 1'b0) begin n_err++; $display("FAIL reset_starve: got %b want 0", bus.starve); end
    n_vec++; if (bus.wait_cnt !== 4'd0) begin n_err++; $display("FAIL reset_wait_cnt: got %0d want 0", bus.wait_cnt); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b0; bus.gnt = 1'b0; rst_n = 1'b1;
    repeat (3) tick();
    // anything latched during reset would have raised req by now
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL reset_no_push_req: got %b want 0", bus.req); end
  endtask

  task automatic test_basic();
    logic [7:0] d      [3] = '{8'hA1, 8'hA2, 8'hA3};
    logic       exp_req[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_ov [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_od [7] = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'hA3};
    bus.gnt = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.in_valid = (c < 3);
      bus.in_data  = (c < 3) ? d[c] : 8'h00;
      tick();
      n_vec++; if (bus.req !== exp_req[c]) begin n_err++; $display("FAIL basic_req[%0d]: got %b want %b", c, bus.req, exp_req[c]); end
      n_vec++; if (bus.out_valid !== exp_ov[c]) begin n_err++; $display("FAIL basic_out_valid[%0d]: got %b want %b", c, bus.out_valid, exp_ov[c]); end
      n_vec++; if (bus.out_data !== exp_od[c]) begin n_err++; $display("FAIL basic_out_data[%0d]: got %h want %h", c, bus.out_data, exp_od[c]); end
    end
    bus.gnt = 1'b0;
  endtask

  task automatic test_burst();
    logic       exp_req[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_ov [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_od [10] = '{8'hA3, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB3, 8'hB4, 8'hB5, 8'hB5};
    bus.gnt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (c < 6);
      bus.in_data  = 8'hB0 + 8'(c);
      tick();
      n_vec++; if (bus.req !== exp_req[c]) begin n_err++; $display("FAIL burst_req[%0d]: got %b want %b", c, bus.req, exp_req[c]); end
      n_vec++; if (bus.out_valid !== exp_ov[c]) begin n_err++; $display("FAIL burst_out_valid[%0d]: got %b want %b", c, bus.out_valid, exp_ov[c]); end
      n_vec++; if (bus.out_data !== exp_od[c]) begin n_err++; $display("FAIL burst_out_data[%0d]: got %h want %h", c, bus.out_data, exp_od[c]); end
    end
    bus.in_valid = 1'b0; bus.gnt = 1'b0;
  endtask

  task automatic test_full();
    logic       exp_req[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_ov [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_od [10] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC7};
    bus.gnt = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC0 + 8'(c);
      tick();
      n_vec++; if (bus.in_ready !== (c < 7)) begin n_err++; $display("FAIL full_in_ready[%0d]: got %b want %b", c, bus.in_ready, (c < 7)); end
    end
    bus.in_data = 8'hEE;
    tick();
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_hold_in_ready: got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b0; bus.gnt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++; if (bus.req !== exp_req[c]) begin n_err++; $display("FAIL full_req[%0d]: got %b want %b", c, bus.req, exp_req[c]); end
      n_vec++; if (bus.out_valid !== exp_ov[c]) begin n_err++; $display("FAIL full_out_valid[%0d]: got %b want %b", c, bus.out_valid, exp_ov[c]); end
      n_vec++; if (bus.out_data !== exp_od[c]) begin n_err++; $display("FAIL full_out_data[%0d]: got %h want %h", c, bus.out_data, exp_od[c]); end
      if (c == 0) begin
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after_pop: got %b want 1", bus.in_ready); end
      end
    end
    bus.gnt = 1'b0;
  endtask

  task automatic test_starve();
    int exp_w;
    bus.gnt = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hF0;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 2; k <= 22; k++) begin
      tick();
      exp_w = (k - 2 > TIMEOUT) ? TIMEOUT : k - 2;
      n_vec++; if (bus.wait_cnt !== 4'(exp_w)) begin n_err++; $display("FAIL starve_wait_cnt[%0d]: got %0d want %0d", k, bus.wait_cnt, exp_w); end
      n_vec++; if (bus.starve !== (exp_w == TIMEOUT)) begin n_err++; $display("FAIL starve_flag[%0d]: got %b want %b", k, bus.starve, (exp_w == TIMEOUT)); end
    end
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL starve_pop_valid: got %b want 1", bus.out_valid); end
    n_vec++; if (bus.out_data !== 8'hF0) begin n_err++; $display("FAIL starve_pop_data: got %h want f0", bus.out_data); end
    n_vec++; if (bus.starve !== 1'b0) begin n_err++; $display("FAIL starve_clear: got %b want 0", bus.starve); end
    n_vec++; if (bus.wait_cnt !== 4'd0) begin n_err++; $display("FAIL starve_wait_clear: got %0d want 0", bus.wait_cnt); end
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL starve_release_req: got %b want 0", bus.req); end
    tick();
  endtask

  task automatic test_toggle_reset();
    logic       gseq   [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_req[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       exp_ov [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_od [7] = '{8'hE0, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE3, 8'hE4};
    bus.gnt = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hE0 + 8'(c);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus.gnt = gseq[c];
      tick();
      n_vec++; if (bus.req !== exp_req[c]) begin n_err++; $display("FAIL toggle_req[%0d]: got %b want %b", c, bus.req, exp_req[c]); end
      n_vec++; if (bus.out_valid !== exp_ov[c]) begin n_err++; $display("FAIL toggle_out_valid[%0d]: got %b want %b", c, bus.out_valid, exp_ov[c]); end
      n_vec++; if (bus.out_data !== exp_od[c]) begin n_err++; $display("FAIL toggle_out_data[%0d]: got %h want %h", c, bus.out_data, exp_od[c]); end
    end
    // asynchronous reset mid-burst, one word (E5) still buffered
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL midrst_req: got %b want 0", bus.req); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL midrst_out_data: got %h want 00", bus.out_data); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL postrst_req: got %b want 0", bus.req); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL postrst_out_valid: got %b want 0", bus.out_valid); end
    bus.gnt = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.gnt = 1'b0;
    test_reset();
    test_basic();
    test_burst();
    test_full();
    test_starve();
    test_toggle_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
